// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul sequencer: array limits, FSM state
// encoding and helpers for element counts and the MAC-enable mask.
package matmul_pkg;

  localparam int unsigned MAX_DIM   = 3;
  localparam int unsigned MAX_ELEMS = 18;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    STREAM,
    MAC,
    DONE
  } state_e;

  // Bit (r*3+c) enables the MAC at result position (r,c).
  function automatic logic [8:0] mac_mask(input logic [1:0] row_w,
                                          input logic [1:0] col_x);
    logic [8:0] m;
    m = '0;
    for (int unsigned r = 0; r < MAX_DIM; r++) begin
      for (int unsigned c = 0; c < MAX_DIM; c++) begin
        if (r < 32'(row_w) && c < 32'(col_x)) begin
          m[4'(r * MAX_DIM + c)] = 1'b1;
        end
      end
    end
    return m;
  endfunction

  function automatic logic [3:0] elem_count(input logic [1:0] row,
                                            input logic [1:0] col);
    return 4'(row) * 4'(col);
  endfunction

endpackage

// File: rtl/matmul_seq_ctrl_elem_buffer.sv
// Operand buffer for the matmul sequencer: MAX_ELEMS x DW register file.
// Ports: clk_i/rst_ni (async active-low reset, contents cleared),
//        we_i/wp_i/wdata_i synchronous write, rp_i/rdata_o combinational read.
module elem_buffer
  import matmul_pkg::*;
#(
  parameter int unsigned DW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [4:0]    wp_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [4:0]    rp_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [MAX_ELEMS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MAX_ELEMS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (wp_i < 5'(MAX_ELEMS))) begin
      mem_q[wp_i] <= wdata_i;
    end
  end

  assign rdata_o = (rp_i < 5'(MAX_ELEMS)) ? mem_q[rp_i] : '0;

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the matmul MAC array. Collects W then X elements from a
// valid/ready host stream, replays them as an unbroken one-per-cycle burst
// with clear/load_mac sequencing, then pulses done after a compute window.
// Ports: clk, clear_n (async active-low reset); start + *_in dims (job
// request, err pulse on invalid dims); elem_valid/elem_data/elem_ready
// (host stream); mac_clear, data_in, load_mac, row_w/col_w/row_x/col_x
// (to matmul); busy, done, err (status). All outputs are registered.
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int unsigned COMPUTE_CYCLES = 8,
  parameter int unsigned DW             = 4
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          start,
  input  logic [1:0]    row_w_in,
  input  logic [1:0]    col_w_in,
  input  logic [1:0]    row_x_in,
  input  logic [1:0]    col_x_in,
  input  logic          elem_valid,
  input  logic [DW-1:0] elem_data,
  output logic          elem_ready,
  output logic          mac_clear,
  output logic [DW-1:0] data_in,
  output logic [8:0]    load_mac,
  output logic [1:0]    row_w,
  output logic [1:0]    col_w,
  output logic [1:0]    row_x,
  output logic [1:0]    col_x,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned CW = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

  state_e        state_q, state_d;
  logic [4:0]    wp_q, wp_d;
  logic [4:0]    k_q, k_d;
  logic [4:0]    n_q, n_d;
  logic [CW-1:0] mc_q, mc_d;
  logic [1:0]    row_w_q, row_w_d, col_w_q, col_w_d;
  logic [1:0]    row_x_q, row_x_d, col_x_q, col_x_d;
  logic          mac_clear_q, mac_clear_d;
  logic          elem_ready_q, elem_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [DW-1:0] data_in_q, data_in_d;
  logic [8:0]    load_mac_q, load_mac_d;

  logic          buf_we;
  logic [4:0]    buf_rp;
  logic [DW-1:0] buf_rdata;
  logic [4:0]    kn;
  logic          dims_bad;

  elem_buffer #(
    .DW(DW)
  ) u_buf (
    .clk_i  (clk),
    .rst_ni (clear_n),
    .we_i   (buf_we),
    .wp_i   (wp_q),
    .wdata_i(elem_data),
    .rp_i   (buf_rp),
    .rdata_o(buf_rdata)
  );

  assign dims_bad = (row_w_in == 2'd0) || (col_w_in == 2'd0) ||
                    (row_x_in == 2'd0) || (col_x_in == 2'd0) ||
                    (col_w_in != row_x_in);

  always_comb begin
    state_d      = state_q;
    wp_d         = wp_q;
    k_d          = k_q;
    n_d          = n_q;
    mc_d         = mc_q;
    row_w_d      = row_w_q;
    col_w_d      = col_w_q;
    row_x_d      = row_x_q;
    col_x_d      = col_x_q;
    mac_clear_d  = mac_clear_q;
    elem_ready_d = elem_ready_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    data_in_d    = data_in_q;
    load_mac_d   = load_mac_q;
    buf_we       = 1'b0;
    buf_rp       = '0;
    kn           = k_q + 5'd1;

    unique case (state_q)
      IDLE: begin
        mac_clear_d = 1'b1;
        if (start) begin
          if (dims_bad) begin
            err_d = 1'b1;
          end else begin
            row_w_d      = row_w_in;
            col_w_d      = col_w_in;
            row_x_d      = row_x_in;
            col_x_d      = col_x_in;
            n_d          = 5'(elem_count(row_w_in, col_w_in)) +
                           5'(elem_count(row_x_in, col_x_in));
            load_mac_d   = '0;
            elem_ready_d = 1'b1;
            busy_d       = 1'b1;
            wp_d         = '0;
            state_d      = FILL;
          end
        end
      end

      FILL: begin
        if (elem_valid && elem_ready_q) begin
          buf_we = 1'b1;
          wp_d   = wp_q + 5'd1;
          if (wp_q == n_q - 5'd1) begin
            state_d      = STREAM;
            elem_ready_d = 1'b0;
            mac_clear_d  = 1'b0;
            k_d          = '0;
            // buf[0] is the element being written right now when N == 1,
            // so forward it instead of reading the not-yet-updated entry.
            data_in_d    = (wp_q == 5'd0) ? elem_data : buf_rdata;
            if (n_q == 5'd1) begin
              load_mac_d = mac_mask(row_w_q, col_x_q);
            end
          end
        end
      end

      STREAM: begin
        if (k_q == n_q - 5'd1) begin
          state_d = MAC;
          mc_d    = '0;
        end else begin
          buf_rp    = kn;
          k_d       = kn;
          data_in_d = buf_rdata;
          if (kn == n_q - 5'd1) begin
            load_mac_d = mac_mask(row_w_q, col_x_q);
          end
        end
      end

      MAC: begin
        if (mc_q == CW'(COMPUTE_CYCLES - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          mc_d = mc_q + 1'b1;
        end
      end

      DONE: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        mac_clear_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q      <= IDLE;
      wp_q         <= '0;
      k_q          <= '0;
      n_q          <= '0;
      mc_q         <= '0;
      row_w_q      <= '0;
      col_w_q      <= '0;
      row_x_q      <= '0;
      col_x_q      <= '0;
      mac_clear_q  <= 1'b1;
      elem_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      data_in_q    <= '0;
      load_mac_q   <= '0;
    end else begin
      state_q      <= state_d;
      wp_q         <= wp_d;
      k_q          <= k_d;
      n_q          <= n_d;
      mc_q         <= mc_d;
      row_w_q      <= row_w_d;
      col_w_q      <= col_w_d;
      row_x_q      <= row_x_d;
      col_x_q      <= col_x_d;
      mac_clear_q  <= mac_clear_d;
      elem_ready_q <= elem_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      data_in_q    <= data_in_d;
      load_mac_q   <= load_mac_d;
    end
  end

  assign elem_ready = elem_ready_q;
  assign mac_clear  = mac_clear_q;
  assign data_in    = data_in_q;
  assign load_mac   = load_mac_q;
  assign row_w      = row_w_q;
  assign col_w      = col_w_q;
  assign row_x      = row_x_q;
  assign col_x      = col_x_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Self-checking bench for matmul_seq_ctrl: table of jobs (dims, elements,
// expected mask, host pacing, stray starts, mid-burst reset) plus
// hand-written rejected-start sequences.
module tb_matmul_seq_ctrl;

  localparam int C = 8;

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] row_w_in = '0, col_w_in = '0, row_x_in = '0, col_x_in = '0;
  logic       elem_valid = 1'b0;
  logic [3:0] elem_data = '0;

  logic       elem_ready, mac_clear, busy, done, err;
  logic [3:0] data_in;
  logic [8:0] load_mac;
  logic [1:0] row_w, col_w, row_x, col_x;

  matmul_seq_ctrl #(
    .COMPUTE_CYCLES(C),
    .DW(4)
  ) dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .start     (start),
    .row_w_in  (row_w_in),
    .col_w_in  (col_w_in),
    .row_x_in  (row_x_in),
    .col_x_in  (col_x_in),
    .elem_valid(elem_valid),
    .elem_data (elem_data),
    .elem_ready(elem_ready),
    .mac_clear (mac_clear),
    .data_in   (data_in),
    .load_mac  (load_mac),
    .row_w     (row_w),
    .col_w     (col_w),
    .row_x     (row_x),
    .col_x     (col_x),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  rw, cw, rx, cx;
    int          n;
    logic [71:0] e;      // element i at e[4*i +: 4]
    logic [8:0]  mask;
    bit          toggle; // host valid only on odd cycles
    bit          poke;   // stray starts during FILL and MAC
    int          abort_k;
  } vec_t;

  vec_t tbl [7];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t mk(input logic [1:0] rw, cw, rx, cx, input int n,
                              input logic [71:0] e, input logic [8:0] mask,
                              input bit toggle, input bit poke, input int abort_k);
    vec_t v;
    v.rw = rw; v.cw = cw; v.rx = rx; v.cx = cx; v.n = n; v.e = e;
    v.mask = mask; v.toggle = toggle; v.poke = poke; v.abort_k = abort_k;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_mac_clear"}, 32'(mac_clear), 1);
    chk({nm, "_load_mac"}, 32'(load_mac), 0);
    chk({nm, "_data_in"}, 32'(data_in), 0);
    chk({nm, "_dims"}, 32'({row_w, col_w, row_x, col_x}), 0);
    chk({nm, "_elem_ready"}, 32'(elem_ready), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_done"}, 32'(done), 0);
    chk({nm, "_err"}, 32'(err), 0);
  endtask

  task automatic run_job(input vec_t v);
    int a, idx, k;
    bit fin;
    logic [3:0] ev;
    a = -1; idx = 0; fin = 0;
    @(negedge clk);
    start = 1'b1;
    row_w_in = v.rw; col_w_in = v.cw; row_x_in = v.rx; col_x_in = v.cx;
    elem_valid = 1'b0;
    for (int t = 1; t <= 400 && !fin; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (a < 0) begin
        if (t == 1) begin
          chk("start_dims", 32'({row_w, col_w, row_x, col_x}), 32'({v.rw, v.cw, v.rx, v.cx}));
          chk("start_busy", 32'(busy), 1);
          chk("start_load_mac", 32'(load_mac), 0);
        end
        chk("fill_ready", 32'(elem_ready), 1);
        chk("fill_clear", 32'(mac_clear), 1);
        if (v.poke && t == 2) begin
          start = 1'b1;
          row_w_in = 2'd1; col_w_in = 2'd1; row_x_in = 2'd1; col_x_in = 2'd1;
        end
        elem_valid = v.toggle ? (t % 2 == 1) : 1'b1;
        elem_data  = v.e[idx*4 +: 4];
        if (elem_valid) begin
          idx++;
          if (idx == v.n) a = t;
        end
      end else begin
        elem_valid = 1'b0;
        k = t - a - 1;
        if (k == 0) chk("ready_drop", 32'(elem_ready), 0);
        if (k < v.n) begin
          ev = v.e[k*4 +: 4];
          chk("burst_data", 32'(data_in), 32'(ev));
          chk("burst_clear", 32'(mac_clear), 0);
          chk("burst_load_mac", 32'(load_mac), (k == v.n - 1) ? 32'(v.mask) : 0);
          if (k == v.abort_k) begin
            clear_n = 1'b0;
            #1;
            check_reset("abort");
            @(negedge clk);
            clear_n = 1'b1;
            fin = 1;
          end
        end else if (k < v.n + C) begin
          ev = v.e[(v.n-1)*4 +: 4];
          chk("mac_load_mac", 32'(load_mac), 32'(v.mask));
          chk("mac_data", 32'(data_in), 32'(ev));
          chk("mac_done", 32'(done), 0);
          if (v.poke && k == v.n + 2) begin
            start = 1'b1;
            row_w_in = 2'd1; col_w_in = 2'd1; row_x_in = 2'd1; col_x_in = 2'd1;
          end
        end else if (k == v.n + C) begin
          chk("done_pulse", 32'(done), 1);
          chk("done_busy", 32'(busy), 1);
        end else begin
          chk("idle_done", 32'(done), 0);
          chk("idle_busy", 32'(busy), 0);
          chk("idle_clear", 32'(mac_clear), 1);
          chk("idle_load_mac", 32'(load_mac), 32'(v.mask));
          chk("idle_dims", 32'({row_w, col_w, row_x, col_x}), 32'({v.rw, v.cw, v.rx, v.cx}));
          fin = 1;
        end
      end
    end
    if (!fin) begin
      n_checks++;
      n_fail++;
      $display("FAIL job_timeout: got no completion expected done within 400 cycles");
    end
  endtask

  // Invalid start from IDLE: err one cycle later, nothing else moves.
  task automatic err_case(input logic [1:0] rw, cw, rx, cx,
                          input logic [7:0] prev_dims, input logic [8:0] prev_mask);
    @(negedge clk);
    start = 1'b1;
    row_w_in = rw; col_w_in = cw; row_x_in = rx; col_x_in = cx;
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", 32'(err), 1);
    chk("err_busy", 32'(busy), 0);
    chk("err_ready", 32'(elem_ready), 0);
    chk("err_clear", 32'(mac_clear), 1);
    chk("err_dims", 32'({row_w, col_w, row_x, col_x}), 32'(prev_dims));
    chk("err_load_mac", 32'(load_mac), 32'(prev_mask));
    @(negedge clk);
    chk("err_end", 32'(err), 0);
    chk("err_idle_busy", 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(2'd3, 2'd3, 2'd3, 2'd3, 18, 72'h01AAA987654321012F, 9'h1FF, 0, 0, -1);
    tbl[1] = mk(2'd2, 2'd2, 2'd2, 2'd2,  8, 72'hFBAAA321,           9'b000011011, 1, 0, -1);
    tbl[2] = mk(2'd3, 2'd2, 2'd2, 2'd3, 12, 72'hCBA987654321,       9'h1FF, 0, 0, -1);
    tbl[3] = mk(2'd1, 2'd1, 2'd1, 2'd1,  2, 72'h2A,                 9'h001, 0, 0, -1);
    tbl[4] = mk(2'd2, 2'd2, 2'd2, 2'd2,  8, 72'hCBA98765,           9'b000011011, 0, 1, -1);
    tbl[5] = mk(2'd2, 2'd2, 2'd2, 2'd2,  8, 72'h19876543,           9'b000011011, 0, 0, 5);
    tbl[6] = mk(2'd1, 2'd1, 2'd1, 2'd1,  2, 72'h97,                 9'h001, 0, 0, -1);

    @(negedge clk);
    check_reset("reset");
    @(negedge clk);
    clear_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_job(tbl[i]);
      if (i == 3) begin
        err_case(2'd1, 2'd2, 2'd3, 2'd1, 8'b01010101, 9'h001);
        err_case(2'd0, 2'd1, 2'd1, 2'd1, 8'b01010101, 9'h001);
      end
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_seq_ctrl.md
# matmul_seq_ctrl

Sequencer for the `matmul` MAC-array datapath (up to 3×3 × 3×3, 4-bit elements).
- Accepts matrix dimensions and a start command.
- Collects the W and X operands from a valid/ready host stream into a local buffer.
- Replays the buffer to `matmul` as an unbroken one-element-per-cycle burst, with correct `clear`/`load_mac` sequencing.
- Signals completion after a fixed compute window.

It sits between the host/test harness and `matmul`, replacing hand-driven stimulus.

## Interface
Parameters:
- COMPUTE_CYCLES, 8, cycles `load_mac` is held before `done` is raised (≥1).
- DW, 4, element width.

Ports:
- clk  in  1  system clock, rising edge.
- clear_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a job; sampled only in IDLE.
- row_w_in, col_w_in, row_x_in, col_x_in  in  2 each  job dimensions, sampled with `start`.
- elem_valid  in  1  host element valid.
- elem_data  in  DW  host element: W row-major first, then X in `matmul` storage order.
- elem_ready  out  1  controller accepts element this cycle.
- mac_clear  out  1  drives `matmul` `clear` (active-high).
- data_in  out  DW  drives `matmul` `data_in`.
- load_mac  out  9  drives `matmul` `load_mac`.
- row_w, col_w, row_x, col_x  out  2 each  registered dimensions to `matmul`.
- busy  out  1  job in progress (FILL/STREAM/MAC/DONE).
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse: start rejected.

## Operation
- Reset values: mac_clear=1, load_mac=0, data_in=0, all dims=0, elem_ready=0, busy=0, done=0, err=0; state IDLE; pointers 0. Reset mid-job aborts immediately with the same values. No partial state survives.
- Element counts:
  - n_w = row_w·col_w (4 bits, ≤9).
  - N = n_w + row_x·col_x (5 bits, ≤18).
  - Computed once, at start acceptance.
- Validity check at start: any dim = 0, or col_w ≠ row_x → err pulse next cycle, stay IDLE, no output changes.
- IDLE:
  - mac_clear=1.
  - load_mac keeps its previous job's value, so results stay visible.
  - A valid start latches the dims, asserts mac_clear=1 and load_mac=0, then moves to FILL.
- FILL:
  - elem_ready=1.
  - Each elem_valid&elem_ready writes buf[wp]; wp increments.
  - On the accept with wp = N−1, go to STREAM with elem_ready=0.
  - elem_valid while elem_ready=0 is ignored.
- STREAM, N cycles, k = 0..N−1:
  - mac_clear=0 and data_in=buf[k].
  - mac_clear falls in the same cycle buf[0] appears.
  - In cycle k=N−1, load_mac = mask: bit (r·3+c) set for r<row_w, c<col_x.
  - Examples: 2×2→9'b000011011; 1×1→9'b000000001; 3×2·2×3→9'h1FF.
- MAC: COMPUTE_CYCLES cycles. load_mac held; data_in holds buf[N−1].
- DONE: done=1 for one cycle, then IDLE. busy falls with the entry to IDLE.
- start while busy: ignored, no err.
- Simultaneous start and elem_valid in IDLE: the element is not accepted.

## Timing
- Start accepted at cycle s: FILL begins s+1, and elem_ready=1 from s+1.
- Last element accepted at cycle a:
  - STREAM occupies a+1 … a+N.
  - load_mac is asserted at a+N.
  - MAC occupies a+N+1 … a+N+COMPUTE_CYCLES.
  - done at a+N+COMPUTE_CYCLES+1.
- Back-to-back host (valid held high): a = s+N, so done = s+2N+COMPUTE_CYCLES+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `matmul_pkg`:
  - MAX_DIM=3, MAX_ELEMS=18.
  - State enum {IDLE, FILL, STREAM, MAC, DONE}.
  - Function `mac_mask(row_w, col_x)` returning 9 bits.
  - Function `elem_count(row, col)`.
- Sub-module `elem_buffer`:
  - 18×DW register file.
  - Synchronous write port (we, wp); combinational read (rp).
  - Reset to 0.
- The FSM and counters stay in the top.

## Test plan
- 3×3·3×3, 18 elements 15,2,1,0,1,2,3,4,5,6,7,8,9,10,10,10,1,0, valid held high → data_in replays the sequence on 18 consecutive cycles; load_mac=9'h1FF on the 18th; done at s+45.
- 2×2·2×2, elements 1,2,3,10,10,10,11,15, valid toggling every other cycle → identical contiguous 8-cycle burst; load_mac=9'b000011011.
- 3×2·2×3, 12 elements, then 1×1·1×1 (10,2) → masks 9'h1FF then 9'h001; mac_clear=1 between jobs; dims update on each start.
- Start with col_w=2, row_x=3, and separately with row_w=0 → err pulse one cycle later; busy, elem_ready and mac_clear unchanged.
- clear_n low during STREAM at k=5 → all outputs at reset values immediately. A new 1×1 job after release completes normally.
- start pulsed during FILL and MAC → ignored; done timing unchanged.
